// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready pipeline of STAGES register stages with bubble
// collapsing, programmable data reset value and synchronous flush.
// Optional occupancy counter output cnt_o is built when PIPE_REG_CNT_EN is defined.
module pipe_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] dat_o
`ifdef PIPE_REG_CNT_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] cnt_o
`endif
);

  logic [STAGES-1:0]     vld_q;
  logic [STAGES-1:0]     en;
  logic [STAGES-1:0]     up_vld;
  logic [STAGES-1:0]     load;
  logic [DATA_WIDTH-1:0] dat_q  [STAGES];
  logic [DATA_WIDTH-1:0] up_dat [STAGES];

  // A stage may advance when it is empty or everything downstream of it can
  // advance; written as a running OR from the output side to keep the chain
  // free of combinational self-reference on one vector.
  always_comb begin : enable_chain
    logic acc;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc = ready_i;
    en  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc   = acc | ~vld_q[k];
      en[k] = acc;
    end
  end

  always_comb begin : upstream_view
    up_vld[0] = valid_i;
    up_dat[0] = dat_i;
    for (int k = 1; k < STAGES; k++) begin
      up_vld[k] = vld_q[k-1];
      up_dat[k] = dat_q[k-1];
    end
  end

  // Data only loads on a valid upstream beat, and never during flush, so empty
  // stages keep their old payload.
  assign load    = en & up_vld & {STAGES{~flush_i}};
  assign ready_o = en[0] & ~flush_i;
  assign valid_o = vld_q[STAGES-1];
  assign dat_o   = dat_q[STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all stages see pre-edge values.
    if (!rst_n_i) begin
      vld_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= (vld_q & ~en) | (up_vld & en);
    end
  end

  // NOTE: the data registers are reset deliberately, since RESET_VAL must appear on dat_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < STAGES; k++) dat_q[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) dat_q[k] <= up_dat[k];
      end
    end
  end

`ifdef PIPE_REG_CNT_EN
  localparam int CNT_W = $clog2(STAGES + 1);

  logic             in_hs;
  logic             out_hs;
  logic [CNT_W-1:0] cnt_q;

  assign in_hs  = valid_i & ready_o;
  assign out_hs = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (in_hs && !out_hs) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (out_hs && !in_hs) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic pipeline register: a chain of STAGES valid/ready register stages carrying DATA_WIDTH-bit payloads, with per-stage bubble collapsing, programmable reset value and a synchronous flush. It is the next generation of the single-flop `dff*` primitives. Datapaths insert it wherever a timing cut or retiming depth is needed on a handshaked stream, for example between bus adapters, FIFOs and IP cores.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1).
- STAGES, 2, number of register stages (≥1).
- RESET_VAL, '0, DATA_WIDTH-bit value loaded into every stage data register at reset.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset. Asynchronous and active-low: assertion clears state immediately, independent of clk_i.
- flush_i  input  1  synchronous flush; drops all in-flight beats.
- valid_i  input  1  upstream beat valid.
- ready_o  output  1  upstream may transfer this cycle.
- dat_i  input  DATA_WIDTH  upstream payload.
- valid_o  output  1  downstream beat valid (last stage valid flag).
- ready_i  input  1  downstream accepts this cycle.
- dat_o  output  DATA_WIDTH  downstream payload (last stage data register).
- cnt_o  output  $clog2(STAGES+1)  occupancy; present only with PIPE_REG_CNT_EN.

## Operation
- State per stage k (0 = input side, STAGES-1 = output side):
  - vld[k], 1 bit.
  - dat[k], DATA_WIDTH bits.
- Stage enable: en[k] = ~vld[k] | en[k+1], with en[STAGES] = ready_i. The ready chain is combinational across all stages and gives bubble collapsing.
- ready_o = en[0] & ~flush_i.
- Input handshake: valid_i & ready_o. Output handshake: valid_o & ready_i.
- On a clock edge, when en[k] is set:
  - vld[k] takes the upstream valid: valid_i for k=0, vld[k-1] otherwise.
  - dat[k] takes the upstream data, but only when that upstream valid is 1.
- Data registers never load on an invalid upstream beat. Data of an empty stage holds its last value, which keeps the stage clock-gating friendly.
- Flush:
  - On any edge with flush_i=1, all vld[k] become 0. Flush has priority over every shift.
  - dat[k] is unchanged by flush.
  - The output handshake in the flush cycle still counts as a transfer to downstream.
  - No input handshake can occur in the flush cycle, because ready_o=0.
- Ordering: beats leave in arrival order. No beat is duplicated or lost except by flush or reset.
- Payload is passed through unmodified. No arithmetic is performed on data.

## Timing
- Reset (rst_n_i low, asynchronous):
  - all vld = 0, so valid_o = 0;
  - all dat = RESET_VAL, so dat_o = RESET_VAL;
  - cnt_o = 0;
  - ready_o = 1 whenever flush_i = 0, including while reset is asserted.
- Reset mid-operation discards every in-flight beat immediately. The first beat after deassertion sees an empty pipe.
- Latency into an empty pipe: a beat accepted at edge N appears on valid_o/dat_o after edge N+STAGES-1, i.e. STAGES cycles from accept to output.
- Throughput: one beat per cycle whenever ready_i is held high.
- Full pipe (all vld=1) with ready_i=0: ready_o=0 in the same cycle, combinationally.
- Full pipe with ready_i=1: ready_o=1, and in one cycle one beat enters while one beat leaves.
- Partial pipe with ready_i=0: new beats are accepted until every stage is full. Holes collapse one stage per cycle.
- valid_o and dat_o are driven straight from flops. ready_o depends combinationally on ready_i and flush_i.
- Once valid_o=1, it stays 1 and dat_o stays stable until the output handshake, flush or reset.

## Configuration
- PIPE_REG_CNT_EN defined:
  - cnt_o exists and is driven from a registered counter.
  - Counter update: +1 on input handshake only, −1 on output handshake only, unchanged when both or neither occur.
  - Flush forces the counter to 0. Reset forces it to 0.
  - cnt_o always equals the popcount of vld.
- PIPE_REG_CNT_EN undefined: the cnt_o port and the counter logic are absent. All other behaviour is identical.

## Test plan
Each scenario uses DATA_WIDTH=8, STAGES=3, RESET_VAL=8'hA5 unless stated otherwise.

- Reset value: hold rst_n_i low, then release. Required response: valid_o=0, dat_o=8'hA5, ready_o=1, cnt_o=0.
- Streaming: with ready_i=1, send 8'h01..8'h08 back-to-back from edge 1. Required response: valid_o rises after edge 3 with 8'h01, then one beat per cycle in order through 8'h08, and ready_o is never 0.
- Backpressure: with ready_i=0, send 8'h10, 8'h11, 8'h12, 8'h13.
  - Required response: the first three are accepted, then ready_o=0 and cnt_o=3, with 8'h13 held upstream.
  - Then raise ready_i for 4 cycles. Required response: 8'h10..8'h13 emerge in order and cnt_o returns to 0.
- Bubble collapse: send 8'h20, idle 1 cycle, send 8'h21, all with ready_i=0. Required response: after 2 further cycles both beats occupy stages 2 and 1, and cnt_o=2.
- Flush: fill the pipe with 8'h30..8'h32 under ready_i=0. Assert flush_i together with valid_i=1 and dat_i=8'h33 for one cycle. Required response: ready_o=0 in that cycle, next cycle valid_o=0, cnt_o=0, and 8'h33 is never emitted.
- Asynchronous reset: assert rst_n_i mid-stream between clock edges. Required response: valid_o drops to 0 and dat_o becomes 8'hA5 before the next edge.
